// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-look-ahead adder: defaults, group count helper
// and the per-bit propagate/generate/sum record used inside a CLA group.
package cla_pkg;

    localparam int unsigned DefWidth = 16;
    localparam int unsigned DefGroup = 4;

    typedef struct packed {
        logic p;
        logic g;
        logic sum;
    } cla_pg_t;

    function automatic int unsigned cla_num_groups(int unsigned width, int unsigned group);
        return (group == 0) ? 1 : width / group;
    endfunction

endpackage

// File: rtl/cla_group.sv
// Combinational GROUP-bit carry-look-ahead adder slice; every internal carry is formed
// directly from the incoming carry and the prefix generate/propagate terms.
module cla_group
    import cla_pkg::*;
#(
    parameter int unsigned GROUP = DefGroup
) (
    input  logic [GROUP-1:0] InputA,
    input  logic [GROUP-1:0] InputB,
    input  logic             InputCarry,
    output logic [GROUP-1:0] SumOut,
    output logic             CarryOut,
    output logic             GroupP,
    output logic             GroupG,
    output logic             CarryIntoMsb
);

    cla_pg_t [GROUP-1:0] pg;
    logic    [GROUP:0]   gen_span;   // generate of bits [i-1:0]
    logic    [GROUP:0]   prop_span;  // propagate of bits [i-1:0]
    logic    [GROUP:0]   carry;

    always_comb begin
        pg        = '0;
        gen_span  = '0;
        prop_span = '0;
        carry     = '0;
        SumOut    = '0;
        for (int i = 0; i < GROUP; i++) begin
            pg[i].p = InputA[i] ^ InputB[i];
            pg[i].g = InputA[i] & InputB[i];
        end
        prop_span[0] = 1'b1;
        for (int i = 0; i < GROUP; i++) begin
            gen_span[i+1]  = pg[i].g | (pg[i].p & gen_span[i]);
            prop_span[i+1] = prop_span[i] & pg[i].p;
        end
        for (int i = 0; i <= GROUP; i++) begin
            carry[i] = gen_span[i] | (prop_span[i] & InputCarry);
        end
        for (int i = 0; i < GROUP; i++) begin
            pg[i].sum = pg[i].p ^ carry[i];
            SumOut[i] = pg[i].sum;
        end
    end

    assign CarryOut     = carry[GROUP];
    assign CarryIntoMsb = carry[GROUP-1];
    assign GroupP       = prop_span[GROUP];
    assign GroupG       = gen_span[GROUP];

endmodule

// File: rtl/pipelined_cla_adder.sv
// WIDTH-bit add/subtract unit, one CLA group resolved per pipeline stage, with valid/ready
// streaming: operands skew through the stages and finished sum groups ride along aligned.
module pipelined_cla_adder
    import cla_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth,
    parameter int unsigned GROUP = DefGroup
) (
    input  logic             Clock,
    input  logic             ResetN,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] InputA,
    input  logic [WIDTH-1:0] InputB,
    input  logic             InputCarry,
    input  logic             SubMode,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] SumOut,
    output logic             CarryOut,
    output logic             OverflowOut
);

    localparam int unsigned NGRP = cla_num_groups(WIDTH, GROUP);

    if (GROUP == 0 || GROUP > WIDTH || (WIDTH % GROUP) != 0) begin : g_param_check
        $error("pipelined_cla_adder: WIDTH must be a non-zero multiple of GROUP");
    end

    // Word k holds finished sums in groups [k:0] and untouched operand bits above.
    logic [NGRP-1:0][WIDTH-1:0] a_q, a_d, b_q, b_d, a_s, b_s;
    logic [NGRP-1:0]            c_q, c_d, v_q, v_d, sub_q, sub_d, cin_s;
    logic                       ovf_q, ovf_d;
    logic [NGRP-1:0][GROUP-1:0] grp_sum;
    logic [NGRP-1:0]            grp_co, grp_p, grp_g, grp_cmsb;
    logic                       stall;
    logic                       unused_grp;

    assign stall   = v_q[NGRP-1] & ~OutReady;
    assign InReady = ~stall;

    always_comb begin
        a_s      = '0;
        b_s      = '0;
        cin_s    = '0;
        a_s[0]   = InputA;
        b_s[0]   = SubMode ? ~InputB : InputB;
        cin_s[0] = InputCarry ^ SubMode;
        for (int k = 1; k < NGRP; k++) begin
            a_s[k]   = a_q[k-1];
            b_s[k]   = b_q[k-1];
            cin_s[k] = c_q[k-1];
        end
    end

    for (genvar k = 0; k < NGRP; k++) begin : g_stage
        cla_group #(
            .GROUP (GROUP)
        ) u_grp (
            .InputA       (a_s[k][k*GROUP +: GROUP]),
            .InputB       (b_s[k][k*GROUP +: GROUP]),
            .InputCarry   (cin_s[k]),
            .SumOut       (grp_sum[k]),
            .CarryOut     (grp_co[k]),
            .GroupP       (grp_p[k]),
            .GroupG       (grp_g[k]),
            .CarryIntoMsb (grp_cmsb[k])
        );
    end

    always_comb begin
        a_d      = a_s;
        b_d      = b_s;
        c_d      = grp_co;
        v_d      = '0;
        sub_d    = '0;
        v_d[0]   = InValid;
        sub_d[0] = SubMode;
        for (int k = 1; k < NGRP; k++) begin
            v_d[k]   = v_q[k-1];
            sub_d[k] = sub_q[k-1];
        end
        for (int k = 0; k < NGRP; k++) begin
            a_d[k][k*GROUP +: GROUP] = grp_sum[k];
        end
        ovf_d = grp_cmsb[NGRP-1] ^ grp_co[NGRP-1];
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            a_q   <= '0;
            b_q   <= '0;
            c_q   <= '0;
            v_q   <= '0;
            sub_q <= '0;
            ovf_q <= 1'b0;
        end else if (!stall) begin
            a_q   <= a_d;
            b_q   <= b_d;
            c_q   <= c_d;
            v_q   <= v_d;
            sub_q <= sub_d;
            ovf_q <= ovf_d;
        end
    end

    assign OutValid    = v_q[NGRP-1];
    assign SumOut      = a_q[NGRP-1];
    assign CarryOut    = c_q[NGRP-1] ^ sub_q[NGRP-1];
    assign OverflowOut = ovf_q;

    // Group P/G and the last stage's operand word are not needed by this datapath.
    assign unused_grp = ^{grp_p, grp_g, grp_cmsb, b_q[NGRP-1]};

endmodule
